mem_txn_ctrl: RTL and testbench
===============================

Name: mem_txn_ctrl

Overview:
- Sits between the manchester_baby RAM port and the external host (Pico).
- On each baby memory access, stalls the baby and serialises the access onto an 8-bit four-phase host handshake:
  - header byte first;
  - then 4 data bytes: sent to the host for a write, received from the host for a read.
- For a read, assembles the 32-bit word for the baby, then releases the stall.
- Replaces the free-running ptp_a/ptp_b byte muxing with a flow-controlled transaction stage.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the host_ack_i synchroniser (min 2).
- ADDR_W, 5, baby RAM address width.
- DATA_W, 32, baby RAM word width; must be a multiple of 8.

Ports:
- clock  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- ram_addr_i  in  ADDR_W  baby RAM address
- ram_data_i  in  DATA_W  baby write data
- ram_rw_en_i  in  1  1 = write, 0 = read
- baby_access_i  in  1  one-cycle pulse: baby presents a valid access
- baby_hold_o  out  1  high = baby must not advance (drives clock_toggle low)
- ram_data_o  out  DATA_W  read word to baby
- ram_data_valid_o  out  1  one-cycle pulse when a transaction completes
- host_data_o  out  8  byte to host
- host_data_i  in  8  byte from host
- host_req_o  out  1  four-phase request
- host_dir_o  out  1  0 = block sends byte, 1 = block wants byte
- host_ack_i  in  1  four-phase acknowledge, asynchronous
- txn_count_o  out  16  completed-transaction counter, wraps at 0xFFFF -> 0
- overrun_o  out  1  sticky: baby_access_i seen while not IDLE

Behaviour:
- Reset: all of the following go to 0 and state goes to IDLE:
  - baby_hold_o, host_req_o, host_dir_o, host_data_o, ram_data_o, ram_data_valid_o, txn_count_o, overrun_o;
  - the synchroniser flops.
- Reset mid-transaction: abort immediately, no completion pulse. Host must see host_req_o drop and return ack low.
- ack_s = host_ack_i after SYNC_STAGES flops. All handshake decisions use ack_s only.
- baby_hold_o = baby_access_i (in IDLE) OR state not in {IDLE, DONE}. It is combinational, so the stall starts in the access cycle.
- States:
  - IDLE:
    - on baby_access_i, latch addr, data and rw;
    - byte_idx = 0;
    - go to HDR.
  - HDR:
    - host_data_o = {rw, 2'b00, addr}, zero-extended/truncated to 8 bits;
    - host_dir_o = 0, host_req_o = 1;
    - on ack_s = 1, go to HDR_REL.
  - HDR_REL:
    - host_req_o = 0;
    - on ack_s = 0, go to DATA.
  - DATA:
    - host_dir_o = ~rw, host_req_o = 1;
    - write: host_data_o = data byte[byte_idx], LSB byte first;
    - read: on ack_s = 1, capture host_data_i into byte lane byte_idx of a shadow word (host data must be stable while ack is high);
    - on ack_s = 1, go to DATA_REL.
  - DATA_REL:
    - host_req_o = 0;
    - on ack_s = 0: if byte_idx = DATA_W/8 - 1 go to DONE, else byte_idx + 1 and go to DATA.
  - DONE (one cycle):
    - read: ram_data_o <= shadow word;
    - ram_data_valid_o = 1;
    - txn_count_o + 1;
    - baby_hold_o = 0;
    - go to IDLE.
- ram_data_o changes only in DONE of a read. Writes leave it unchanged.
- baby_access_i outside IDLE: ignored, overrun_o <= 1 (cleared only by reset).
- Minimum transaction latency, access to DONE: 2·(1 + DATA_W/8) handshake phases, each ≥ SYNC_STAGES + 1 cycles.
- host_req_o is registered and glitch-free. host_data_o and host_dir_o are stable the cycle before req rises and until ack_s returns low.

Decomposition:
- Shared package mem_txn_pkg:
  - state enum (IDLE, HDR, HDR_REL, DATA, DATA_REL, DONE);
  - HDR_RW_BIT = 7;
  - BYTES_PER_WORD = DATA_W/8.
- One natural sub-module: sync_ff (SYNC_STAGES-deep synchroniser for host_ack_i, reset to 0).

Test Plan:
- Write, addr 0x1F, data 0xDEADBEEF; host acks each req after 3 cycles:
  - host sees 0x9F, EF, BE, AD, DE with host_dir_o = 0;
  - ram_data_valid_o pulses once;
  - txn_count_o = 1;
  - baby_hold_o high from the access cycle to DONE.
- Read, addr 0x05; host supplies 0x78, 0x56, 0x34, 0x12:
  - header 0x05, host_dir_o = 1 for the data bytes;
  - ram_data_o = 0x12345678 exactly at the DONE cycle;
  - prior ram_data_o held until then.
- Host holds ack high for 20 cycles on byte 2:
  - block waits in DATA_REL with req low;
  - no byte skipped or duplicated;
  - final word is correct.
- reset_i asserted during DATA, byte_idx = 2:
  - next cycle all outputs are 0, state is IDLE, txn_count_o unchanged from 0;
  - a new read afterwards completes correctly.
- baby_access_i pulsed during HDR:
  - overrun_o = 1 and stays 1;
  - the current transaction completes with the original addr;
  - overrun_o is cleared only by reset.
- Preload txn_count_o to 0xFFFF via 65535 fast transactions (or force), then one more write -> txn_count_o = 0x0000.

Source files
------------

// File: rtl/mem_txn_pkg.sv
// Shared types and constants for the baby-to-host memory transaction stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mem_txn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    HDR_REL,
    DATA,
    DATA_REL,
    DONE
  } state_t;

  // Header bit that carries the access direction (1 = write).
  localparam int HDR_RW_BIT     = 7;
  localparam int DATA_W_DEFAULT = 32;
  localparam int BYTES_PER_WORD = DATA_W_DEFAULT / 8;

endpackage

// File: rtl/mem_txn_if.sv
// Bundle of baby RAM-port signals and the 8-bit four-phase host handshake.
// Latency: n/a (wiring only).
// Backpressure: host_ack_i paces every byte; baby_hold_o stalls the baby.
interface mem_txn_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] ram_addr_i;
  logic [DATA_W-1:0] ram_data_i;
  logic              ram_rw_en_i;
  logic              baby_access_i;
  logic              baby_hold_o;
  logic [DATA_W-1:0] ram_data_o;
  logic              ram_data_valid_o;
  logic [7:0]        host_data_o;
  logic [7:0]        host_data_i;
  logic              host_req_o;
  logic              host_dir_o;
  logic              host_ack_i;
  logic [15:0]       txn_count_o;
  logic              overrun_o;

  // Controller side
  modport slave (
    input  ram_addr_i, ram_data_i, ram_rw_en_i, baby_access_i,
    input  host_data_i, host_ack_i,
    output baby_hold_o, ram_data_o, ram_data_valid_o,
    output host_data_o, host_req_o, host_dir_o, txn_count_o, overrun_o
  );

  // Baby + host side
  modport master (
    output ram_addr_i, ram_data_i, ram_rw_en_i, baby_access_i,
    output host_data_i, host_ack_i,
    input  baby_hold_o, ram_data_o, ram_data_valid_o,
    input  host_data_o, host_req_o, host_dir_o, txn_count_o, overrun_o
  );
endinterface

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level (host acknowledge).
// Latency: STAGES clock cycles.
// Backpressure: none.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset_i,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the asynchronous level through the flop chain.
  always_ff @(posedge clock) begin
    if (reset_i) ff <= '0;
    else         ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/mem_txn_ctrl.sv
// Stalls the baby on each RAM access and serialises it as header + data bytes over a four-phase host handshake.
// Latency: 2*(1+DATA_W/8) handshake phases, each at least SYNC_STAGES+1 cycles, from access to completion pulse.
// Backpressure: baby_hold_o stays high until the host has acked every byte; accesses arriving while busy set overrun_o and are dropped.
module mem_txn_ctrl
  import mem_txn_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32
) (
  input  logic       clock,
  input  logic       reset_i,
  mem_txn_if.slave   bus
);

  localparam int NBYTES = DATA_W / 8;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);
  localparam int RAW_W  = ADDR_W + 3;

  state_t            state, next_state;
  logic              ack_s;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] shadow_q;
  logic [DATA_W-1:0] ram_data_q;
  logic [DATA_W-1:0] wr_shift;
  logic              rw_q;
  logic [IDX_W-1:0]  byte_idx;
  logic              is_last;
  logic              req_q;
  logic              valid_q;
  logic              overrun_q;
  logic [15:0]       txn_count_q;
  logic [RAW_W-1:0]  hdr_raw;
  logic [7:0]        hdr_byte;
  logic [7:0]        wr_byte;
  logic              hold;
  logic              dir;
  logic [7:0]        tx_byte;
  logic              finishing;

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clock   (clock),
    .reset_i (reset_i),
    .d       (bus.host_ack_i),
    .q       (ack_s)
  );

  // Header is {rw, 00, addr} fitted to one byte; write bytes go LSB first.
  assign hdr_raw   = {rw_q, 2'b00, addr_q};
  assign hdr_byte  = 8'(hdr_raw);
  assign wr_shift  = data_q >> (8 * byte_idx);
  assign wr_byte   = wr_shift[7:0];
  assign is_last   = (byte_idx == LAST_IDX);
  assign finishing = (state == DATA_REL) && (next_state == DONE);

  // State register.
  always_ff @(posedge clock) begin
    if (reset_i) state <= IDLE;
    else         state <= next_state;
  end

  // Next-state logic: every handshake decision looks only at the synchronised ack.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (bus.baby_access_i) next_state = HDR;
      HDR:      if (ack_s)             next_state = HDR_REL;
      HDR_REL:  if (!ack_s)            next_state = DATA;
      DATA:     if (ack_s)             next_state = DATA_REL;
      DATA_REL: if (!ack_s)            next_state = is_last ? DONE : DATA;
      DONE:                            next_state = IDLE;
      default:                         next_state = IDLE;
    endcase
  end

  // Moore-style outputs; hold also covers the access cycle itself so the baby stalls immediately.
  always_comb begin
    hold    = 1'b0;
    dir     = 1'b0;
    tx_byte = 8'h00;
    case (state)
      IDLE:          hold = bus.baby_access_i;
      HDR, HDR_REL: begin
        hold    = 1'b1;
        tx_byte = hdr_byte;
      end
      DATA, DATA_REL: begin
        hold    = 1'b1;
        dir     = ~rw_q;
        tx_byte = rw_q ? wr_byte : 8'h00;
      end
      default: ;
    endcase
  end

  // Access capture, byte lane stepping and read-byte assembly.
  always_ff @(posedge clock) begin
    if (state == IDLE && bus.baby_access_i) begin
      addr_q   <= bus.ram_addr_i;
      data_q   <= bus.ram_data_i;
      rw_q     <= bus.ram_rw_en_i;
      byte_idx <= '0;
    end else if (state == DATA_REL && !ack_s && !is_last) begin
      byte_idx <= byte_idx + IDX_W'(1);
    end
    if (state == DATA && ack_s && !rw_q) begin
      shadow_q[{byte_idx, 3'b000} +: 8] <= bus.host_data_i;
    end
  end

  // Registered request and completion outputs. Request drops on the same edge the
  // FSM leaves a request state, and only rises one cycle after the byte is on the bus.
  // Completion effects are applied on entry to DONE so they are visible during DONE.
  always_ff @(posedge clock) begin
    if (reset_i) begin
      req_q       <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      txn_count_q <= 16'h0000;
      ram_data_q  <= '0;
    end else begin
      req_q   <= ((state == HDR)  && (next_state == HDR)) ||
                 ((state == DATA) && (next_state == DATA));
      valid_q <= finishing;
      if (finishing) begin
        txn_count_q <= txn_count_q + 16'd1;
        if (!rw_q) ram_data_q <= shadow_q;
      end
      if (state != IDLE && bus.baby_access_i) overrun_q <= 1'b1;
    end
  end

  assign bus.baby_hold_o      = hold;
  assign bus.host_data_o      = tx_byte;
  assign bus.host_dir_o       = dir;
  assign bus.host_req_o       = req_q;
  assign bus.ram_data_o       = ram_data_q;
  assign bus.ram_data_valid_o = valid_q;
  assign bus.txn_count_o      = txn_count_q;
  assign bus.overrun_o        = overrun_q;

endmodule

// File: tb/tb_mem_txn_ctrl.sv
// Bench for mem_txn_ctrl: a behavioural host answers the four-phase handshake, a byte-level model predicts traffic.
// Latency: n/a.
// Backpressure: host ack/release delays are programmable per scenario.
module tb_mem_txn_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NB = DW / 8;

  logic clock = 1'b0;
  logic reset_i = 1'b0;
  always #5 clock = ~clock;

  mem_txn_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_txn_ctrl #(.SYNC_STAGES(2), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock   (clock),
    .reset_i (reset_i),
    .bus     (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;

  // Host behaviour knobs (written by tests only)
  int ack_delay = 3;
  int rel_delay = 3;
  int hold_at   = -1;

  // Host observations (written by host process only)
  logic [8:0] host_log[$];
  logic [7:0] supply[$];
  int relwait_req_hi = 0;
  bit host_timeout = 1'b0;
  logic [7:0] h_b;
  int h_n, h_d;

  // Expected traffic (model)
  logic [8:0]  exp_log[$];
  logic [31:0] exp_ram = 32'h0;
  logic [15:0] exp_count = 16'h0;

  // Four-phase sanity monitor
  int fourphase_viol = 0;
  logic prev_req = 1'b0;

  // Behavioural host: wait for req, ack after a delay, release after req drops.
  initial begin
    bus.host_ack_i  = 1'b0;
    bus.host_data_i = 8'h00;
    forever begin
      @(posedge clock); #3;
      if (bus.host_req_o === 1'b1 && bus.host_ack_i === 1'b0) begin
        for (h_n = 0; h_n < ack_delay; h_n++) begin @(posedge clock); #3; end
        if (bus.host_req_o === 1'b1) begin
          if (bus.host_dir_o === 1'b1) begin
            h_b = (supply.size() > 0) ? supply.pop_front() : 8'h00;
            bus.host_data_i = h_b;
          end else begin
            h_b = bus.host_data_o;
          end
          host_log.push_back({bus.host_dir_o, h_b});
          bus.host_ack_i = 1'b1;
          h_n = 0;
          while (bus.host_req_o !== 1'b0 && h_n < 2000) begin
            @(posedge clock); #3; h_n++;
          end
          if (h_n >= 2000) host_timeout = 1'b1;
          h_d = (host_log.size() == hold_at) ? 20 : rel_delay;
          for (h_n = 0; h_n < h_d; h_n++) begin
            @(posedge clock); #3;
            if (bus.host_req_o === 1'b1) relwait_req_hi++;
          end
          bus.host_ack_i = 1'b0;
        end
      end
    end
  end

  // Request must never rise while the host still holds ack high.
  always @(posedge clock) begin
    #2;
    if (bus.host_req_o === 1'b1 && prev_req === 1'b0 && bus.host_ack_i === 1'b1) fourphase_viol++;
    prev_req = bus.host_req_o;
  end

  // Model: the byte stream and end state a transaction must produce.
  function automatic void expect_txn(input bit rw, input logic [4:0] addr, input logic [31:0] word);
    logic [7:0] h;
    logic [7:0] b;
    h = 8'(addr);
    h[mem_txn_pkg::HDR_RW_BIT] = rw;
    exp_log.delete();
    exp_log.push_back({1'b0, h});
    for (int i = 0; i < NB; i++) begin
      b = word[8*i +: 8];
      exp_log.push_back({~rw, b});
      if (!rw) supply.push_back(b);
    end
    if (!rw) exp_ram = word;
    exp_count = exp_count + 16'd1;
  endfunction

  // Index of first difference between observed and expected byte streams, -1 if equal.
  function automatic int log_diff();
    int n;
    n = (host_log.size() < exp_log.size()) ? host_log.size() : exp_log.size();
    for (int i = 0; i < n; i++) if (host_log[i] !== exp_log[i]) return i;
    if (host_log.size() != exp_log.size()) return n;
    return -1;
  endfunction

  // Drive one baby access and observe it until the completion pulse (bounded).
  task automatic do_txn(input bit rw, input logic [4:0] addr, input logic [31:0] wdata,
                        input int pulse_at,
                        output bit got, output bit hold_acc, output int gaps,
                        output int ram_changes, output logic [31:0] ram_at_valid,
                        output bit hold_at_valid, output bit valid_after);
    logic [31:0] prev_ram;
    int c;
    host_log.delete();
    got = 1'b0; gaps = 0; ram_changes = 0; ram_at_valid = 'x; hold_at_valid = 1'b1;
    @(posedge clock); #1;
    bus.ram_addr_i = addr; bus.ram_data_i = wdata; bus.ram_rw_en_i = rw;
    bus.baby_access_i = 1'b1;
    #1 hold_acc = bus.baby_hold_o;
    prev_ram = bus.ram_data_o;
    @(posedge clock); #1;
    bus.baby_access_i = 1'b0;
    c = 0;
    while (!got && c < 3000) begin
      if (c == pulse_at) begin
        bus.ram_addr_i = ~addr;
        bus.baby_access_i = 1'b1;
      end
      #1;
      if (bus.ram_data_valid_o === 1'b1) begin
        got = 1'b1;
        ram_at_valid = bus.ram_data_o;
        hold_at_valid = bus.baby_hold_o;
      end else begin
        if (bus.baby_hold_o !== 1'b1) gaps++;
        if (bus.ram_data_o !== prev_ram) ram_changes++;
      end
      @(posedge clock); #1;
      bus.baby_access_i = 1'b0;
      c++;
    end
    #1 valid_after = bus.ram_data_valid_o;
  endtask

  task automatic apply_reset();
    @(posedge clock); #1 reset_i = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset_i = 1'b0;
    #1;
    exp_count = 16'h0; exp_ram = 32'h0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if ({bus.baby_hold_o, bus.host_req_o, bus.host_dir_o, bus.ram_data_valid_o, bus.overrun_o} !== 5'b0) begin
      tests_failed++; $display("FAIL reset_ctrl: got %b want 00000", {bus.baby_hold_o, bus.host_req_o, bus.host_dir_o, bus.ram_data_valid_o, bus.overrun_o});
    end
    tests_run++;
    if (bus.host_data_o !== 8'h00) begin tests_failed++; $display("FAIL reset_host_data: got %h want 00", bus.host_data_o); end
    tests_run++;
    if (bus.ram_data_o !== 32'h0) begin tests_failed++; $display("FAIL reset_ram_data: got %h want 0", bus.ram_data_o); end
    tests_run++;
    if (bus.txn_count_o !== 16'h0) begin tests_failed++; $display("FAIL reset_count: got %h want 0", bus.txn_count_o); end
  endtask

  task automatic test_write();
    bit got, hacc, hval, vafter; int gaps, rch; logic [31:0] rv;
    ack_delay = 3; rel_delay = 3;
    expect_txn(1'b1, 5'h1F, 32'hDEADBEEF);
    do_txn(1'b1, 5'h1F, 32'hDEADBEEF, -1, got, hacc, gaps, rch, rv, hval, vafter);
    tests_run++;
    if (got !== 1'b1) begin tests_failed++; $display("FAIL write_done: got %b want 1", got); end
    tests_run++;
    if (((host_log.size() > 0) ? host_log[0] : 9'h1FF) !== 9'h09F) begin
      tests_failed++; $display("FAIL write_header: got %h want 09F", (host_log.size() > 0) ? host_log[0] : 9'h1FF);
    end
    tests_run++;
    if (log_diff() !== -1) begin tests_failed++; $display("FAIL write_bytes: first diff at %0d, got %0d bytes want %0d", log_diff(), host_log.size(), exp_log.size()); end
    tests_run++;
    if ({hacc, gaps == 0, hval, vafter} !== 4'b1100) begin
      tests_failed++; $display("FAIL write_hold: access=%b gaps=%0d at_done=%b valid_after=%b want 1 0 0 0", hacc, gaps, hval, vafter);
    end
    tests_run++;
    if (bus.txn_count_o !== 16'd1) begin tests_failed++; $display("FAIL write_count: got %0d want 1", bus.txn_count_o); end
    tests_run++;
    if (rv !== 32'h0) begin tests_failed++; $display("FAIL write_ram_unchanged: got %h want 0", rv); end
  endtask

  task automatic test_read();
    bit got, hacc, hval, vafter; int gaps, rch; logic [31:0] rv;
    expect_txn(1'b0, 5'h05, 32'h12345678);
    do_txn(1'b0, 5'h05, 32'hA5A5A5A5, -1, got, hacc, gaps, rch, rv, hval, vafter);
    tests_run++;
    if (got !== 1'b1) begin tests_failed++; $display("FAIL read_done: got %b want 1", got); end
    tests_run++;
    if (((host_log.size() > 0) ? host_log[0] : 9'h1FF) !== 9'h005) begin
      tests_failed++; $display("FAIL read_header: got %h want 005", (host_log.size() > 0) ? host_log[0] : 9'h1FF);
    end
    tests_run++;
    if (log_diff() !== -1) begin tests_failed++; $display("FAIL read_bytes: first diff at %0d", log_diff()); end
    tests_run++;
    if (rv !== 32'h12345678) begin tests_failed++; $display("FAIL read_word: got %h want 12345678", rv); end
    tests_run++;
    if (rch !== 0) begin tests_failed++; $display("FAIL read_ram_held: got %0d early changes want 0", rch); end
    tests_run++;
    if (bus.txn_count_o !== exp_count) begin tests_failed++; $display("FAIL read_count: got %0d want %0d", bus.txn_count_o, exp_count); end
  endtask

  task automatic test_ack_hold();
    bit got, hacc, hval, vafter; int gaps, rch, rq0; logic [31:0] rv, w;
    w = $urandom;
    rq0 = relwait_req_hi;
    hold_at = 4;
    expect_txn(1'b0, 5'($urandom), w);
    do_txn(1'b0, exp_log[0][4:0], 32'h0, -1, got, hacc, gaps, rch, rv, hval, vafter);
    hold_at = -1;
    tests_run++;
    if (relwait_req_hi - rq0 !== 0) begin tests_failed++; $display("FAIL hold_req_low: req high for %0d release cycles want 0", relwait_req_hi - rq0); end
    tests_run++;
    if (log_diff() !== -1) begin tests_failed++; $display("FAIL hold_bytes: first diff at %0d, got %0d bytes want 5", log_diff(), host_log.size()); end
    tests_run++;
    if (rv !== w) begin tests_failed++; $display("FAIL hold_word: got %h want %h", rv, w); end
  endtask

  task automatic test_reset_mid();
    bit got, hacc, hval, vafter; int gaps, rch, n; logic [31:0] rv, w;
    ack_delay = 12;
    expect_txn(1'b0, 5'h0A, 32'hCAFEF00D);
    host_log.delete();
    @(posedge clock); #1;
    bus.ram_addr_i = 5'h0A; bus.ram_rw_en_i = 1'b0; bus.baby_access_i = 1'b1;
    @(posedge clock); #1 bus.baby_access_i = 1'b0;
    #1; n = 0;
    while (!(host_log.size() == 3 && bus.host_req_o === 1'b1 && bus.host_ack_i === 1'b0) && n < 2000) begin
      @(posedge clock); #2; n++;
    end
    tests_run++;
    if (n >= 2000) begin tests_failed++; $display("FAIL reset_mid_reach: byte 2 request not seen, got %0d bytes", host_log.size()); end
    reset_i = 1'b1;
    @(posedge clock); #1 reset_i = 1'b0;
    #1;
    exp_count = 16'h0; exp_ram = 32'h0;
    tests_run++;
    if ({bus.baby_hold_o, bus.host_req_o, bus.host_dir_o, bus.ram_data_valid_o, bus.overrun_o, bus.host_data_o} !== 13'b0) begin
      tests_failed++; $display("FAIL reset_mid_outputs: got %b want 0", {bus.baby_hold_o, bus.host_req_o, bus.host_dir_o, bus.ram_data_valid_o, bus.overrun_o, bus.host_data_o});
    end
    tests_run++;
    if (bus.txn_count_o !== 16'h0) begin tests_failed++; $display("FAIL reset_mid_count: got %0d want 0", bus.txn_count_o); end
    repeat (30) @(posedge clock);
    supply.delete();
    ack_delay = 3;
    w = $urandom;
    expect_txn(1'b0, 5'h0A, w);
    do_txn(1'b0, 5'h0A, 32'h0, -1, got, hacc, gaps, rch, rv, hval, vafter);
    tests_run++;
    if (log_diff() !== -1 || rv !== w) begin
      tests_failed++; $display("FAIL reset_mid_next_read: word %h want %h, diff at %0d", rv, w, log_diff());
    end
    tests_run++;
    if (bus.txn_count_o !== 16'd1) begin tests_failed++; $display("FAIL reset_mid_next_count: got %0d want 1", bus.txn_count_o); end
  endtask

  task automatic test_overrun();
    bit got, hacc, hval, vafter; int gaps, rch; logic [31:0] rv, w;
    tests_run++;
    if (bus.overrun_o !== 1'b0) begin tests_failed++; $display("FAIL overrun_initial: got %b want 0", bus.overrun_o); end
    w = $urandom;
    expect_txn(1'b1, 5'h11, w);
    do_txn(1'b1, 5'h11, w, 0, got, hacc, gaps, rch, rv, hval, vafter);
    tests_run++;
    if (bus.overrun_o !== 1'b1) begin tests_failed++; $display("FAIL overrun_set: got %b want 1", bus.overrun_o); end
    tests_run++;
    if (got !== 1'b1 || log_diff() !== -1) begin tests_failed++; $display("FAIL overrun_orig_txn: done=%b diff at %0d", got, log_diff()); end
    w = $urandom;
    expect_txn(1'b1, 5'h03, w);
    do_txn(1'b1, 5'h03, w, -1, got, hacc, gaps, rch, rv, hval, vafter);
    tests_run++;
    if (bus.overrun_o !== 1'b1) begin tests_failed++; $display("FAIL overrun_sticky: got %b want 1", bus.overrun_o); end
    apply_reset();
    tests_run++;
    if (bus.overrun_o !== 1'b0) begin tests_failed++; $display("FAIL overrun_cleared: got %b want 0", bus.overrun_o); end
  endtask

  task automatic test_wrap();
    bit got, hacc, hval, vafter; int gaps, rch; logic [31:0] rv, w;
    @(posedge clock); #1 force dut.txn_count_q = 16'hFFFF;
    @(posedge clock); #1 release dut.txn_count_q;
    exp_count = 16'hFFFF;
    w = $urandom;
    expect_txn(1'b1, 5'h07, w);
    do_txn(1'b1, 5'h07, w, -1, got, hacc, gaps, rch, rv, hval, vafter);
    tests_run++;
    if (bus.txn_count_o !== 16'h0000) begin tests_failed++; $display("FAIL count_wrap: got %h want 0000", bus.txn_count_o); end
  endtask

  task automatic test_random();
    bit got, hacc, hval, vafter, rw; int gaps, rch; logic [31:0] rv, w; logic [4:0] a;
    for (int t = 0; t < 20; t++) begin
      rw = 1'($urandom); a = 5'($urandom); w = $urandom;
      ack_delay = $urandom_range(0, 4); rel_delay = $urandom_range(0, 4);
      expect_txn(rw, a, w);
      do_txn(rw, a, rw ? w : $urandom, -1, got, hacc, gaps, rch, rv, hval, vafter);
      tests_run++;
      if (got !== 1'b1 || log_diff() !== -1) begin
        tests_failed++; $display("FAIL rand_bytes[%0d]: done=%b diff at %0d rw=%b addr=%h", t, got, log_diff(), rw, a);
      end
      tests_run++;
      if (rv !== exp_ram) begin tests_failed++; $display("FAIL rand_ram[%0d]: got %h want %h", t, rv, exp_ram); end
      tests_run++;
      if (bus.txn_count_o !== exp_count) begin tests_failed++; $display("FAIL rand_count[%0d]: got %0d want %0d", t, bus.txn_count_o, exp_count); end
      tests_run++;
      if (gaps !== 0 || hacc !== 1'b1 || hval !== 1'b0) begin
        tests_failed++; $display("FAIL rand_hold[%0d]: gaps=%0d access=%b at_done=%b", t, gaps, hacc, hval);
      end
    end
    ack_delay = 3; rel_delay = 3;
  endtask

  initial begin
    bus.ram_addr_i = '0; bus.ram_data_i = '0; bus.ram_rw_en_i = 1'b0; bus.baby_access_i = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_ack_hold();
    test_reset_mid();
    test_overrun();
    test_wrap();
    test_random();
    tests_run++;
    if (fourphase_viol !== 0) begin tests_failed++; $display("FAIL four_phase: req rose with ack high %0d times want 0", fourphase_viol); end
    tests_run++;
    if (host_timeout !== 1'b0) begin tests_failed++; $display("FAIL host_wait: req never dropped after ack"); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
